// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Purpose: ID-stage data-hazard unit for an in-order 5-stage pipeline.
//   Picks a forwarding source for each ID source operand from the EX, MEM or WB
//   stage. Detects load-use hazards and inserts LOAD_STALL bubbles through a
//   small IDLE/STALL FSM. Keeps a saturating count of bubble cycles.
// Ports:
//   clk                  clock; all state updates on the rising edge
//   reset_n              asynchronous active-low reset
//   id_rs                packed ID source addresses, operand i at [i*REG_AW +: REG_AW]
//   id_src_valid         per-operand "operand is read" flag
//   ex/mem/wb_dest       destination register of each downstream stage
//   ex/mem/wb_rf_enable  stage will write the register file
//   ex_load_instruction  EX holds a load
//   flush                taken branch/jump; squashes ID
//   ext_stall            external hold (memory busy)
//   fwd_sel              packed 2-bit select per operand: 00 RF, 01 EX, 10 MEM, 11 WB
//   pc_enable            PC update enable
//   load_enable          IF/ID register update enable
//   nop_signal           inject a bubble into EX
//   stall_busy           FSM is in STALL
//   stall_cycles         saturating bubble-cycle counter
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [REG_AW-1:0]         ex_dest,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic [REG_AW-1:0]         wb_dest,
  input  logic                      ex_rf_enable,
  input  logic                      mem_rf_enable,
  input  logic                      wb_rf_enable,
  input  logic                      ex_load_instruction,
  input  logic                      flush,
  input  logic                      ext_stall,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      pc_enable,
  output logic                      load_enable,
  output logic                      nop_signal,
  output logic                      stall_busy,
  output logic [CNT_W-1:0]          stall_cycles
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Remaining bubbles after the one issued on the hazard cycle itself.
  localparam logic [1:0] REM_INIT = 2'(LOAD_STALL - 1);

  state_t               state_q, state_d;
  logic [1:0]           rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*NUM_SRC-1:0] fwd_sel_s;
  logic                 lu_match_s;
  logic                 lu_s;
  logic                 pc_en_s;
  logic                 load_en_s;
  logic                 nop_s;

  // Forwarding select per operand and load-use address match against EX.
  always_comb begin : fwd_logic
    logic [REG_AW-1:0] addr_v;
    fwd_sel_s  = '0;
    lu_match_s = 1'b0;
    addr_v     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr_v = id_rs[i*REG_AW +: REG_AW];
      // x0 is hard-wired zero: it never forwards and never stalls.
      if (id_src_valid[i] && (addr_v != '0)) begin
        if (ex_rf_enable && (ex_dest == addr_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b01;
        end else if (mem_rf_enable && (mem_dest == addr_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b10;
        end else if (wb_rf_enable && (wb_dest == addr_v)) begin
          fwd_sel_s[2*i +: 2] = 2'b11;
        end else begin
          fwd_sel_s[2*i +: 2] = 2'b00;
        end
        if (ex_dest == addr_v) begin
          lu_match_s = 1'b1;
        end else begin
          lu_match_s = lu_match_s;
        end
      end else begin
        fwd_sel_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // Load-use hazard is only evaluated from IDLE so a running stall cannot retrigger.
  assign lu_s = (state_q == IDLE) && !flush && ex_load_instruction &&
                ex_rf_enable && lu_match_s;

  // State register, bubble down-counter and stall-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: flush beats everything, ext_stall freezes the FSM.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = 2'd0;
    end else if (ext_stall) begin
      state_d = state_q;
      rem_d   = rem_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu_s && (LOAD_STALL > 1)) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end else begin
            state_d = IDLE;
            rem_d   = 2'd0;
          end
        end
        STALL: begin
          if (rem_q == 2'd1) begin
            state_d = IDLE;
            rem_d   = 2'd0;
          end else begin
            state_d = STALL;
            rem_d   = rem_q - 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // Pipeline control outputs; the hazard cycle already emits its bubble.
  always_comb begin
    pc_en_s   = 1'b1;
    load_en_s = 1'b1;
    nop_s     = 1'b0;
    if (flush) begin
      // Squash ID but let the redirected PC load.
      pc_en_s   = 1'b1;
      load_en_s = 1'b1;
      nop_s     = 1'b1;
    end else if (ext_stall) begin
      pc_en_s   = 1'b0;
      load_en_s = 1'b0;
      nop_s     = 1'b0;
    end else if ((state_q == STALL) || lu_s) begin
      pc_en_s   = 1'b0;
      load_en_s = 1'b0;
      nop_s     = 1'b1;
    end else begin
      pc_en_s   = 1'b1;
      load_en_s = 1'b1;
      nop_s     = 1'b0;
    end
  end

  // Saturating bubble counter; flush bubbles are not hazard stalls.
  always_comb begin
    if (nop_s && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Combinational outputs are held at their quiet values during reset.
  assign fwd_sel      = reset_n ? fwd_sel_s : '0;
  assign pc_enable    = reset_n ? pc_en_s   : 1'b1;
  assign load_enable  = reset_n ? load_en_s : 1'b1;
  assign nop_signal   = reset_n & nop_s;
  assign stall_busy   = (state_q == STALL);
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  localparam int NS = 2;
  localparam int AW = 5;

  logic            clk;
  logic            reset_n;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0]   id_src_valid;
  logic [AW-1:0]   ex_dest, mem_dest, wb_dest;
  logic            ex_rf_enable, mem_rf_enable, wb_rf_enable;
  logic            ex_load_instruction, flush, ext_stall;

  // dut_a: LOAD_STALL=3, wide counter
  logic [2*NS-1:0] a_fwd;
  logic            a_pc, a_le, a_nop, a_busy;
  logic [15:0]     a_cnt;
  // dut_b: LOAD_STALL=1, 2-bit counter
  logic [2*NS-1:0] b_fwd;
  logic            b_pc, b_le, b_nop, b_busy;
  logic [1:0]      b_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_scoreboard_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_STALL(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_src_valid(id_src_valid),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load_instruction(ex_load_instruction), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(a_fwd), .pc_enable(a_pc), .load_enable(a_le), .nop_signal(a_nop),
    .stall_busy(a_busy), .stall_cycles(a_cnt)
  );

  hazard_scoreboard_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_STALL(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_src_valid(id_src_valid),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load_instruction(ex_load_instruction), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(b_fwd), .pc_enable(b_pc), .load_enable(b_le), .nop_signal(b_nop),
    .stall_busy(b_busy), .stall_cycles(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs               = '0;
    id_src_valid        = 2'b00;
    ex_dest             = 5'd0;
    mem_dest            = 5'd0;
    wb_dest             = 5'd0;
    ex_rf_enable        = 1'b0;
    mem_rf_enable       = 1'b0;
    wb_rf_enable        = 1'b0;
    ex_load_instruction = 1'b0;
    flush               = 1'b0;
    ext_stall           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  // load to x7 in EX, operand 0 reads x7
  task automatic drive_load_x7();
    id_rs               = {5'd0, 5'd7};
    id_src_valid        = 2'b01;
    ex_dest             = 5'd7;
    ex_rf_enable        = 1'b1;
    ex_load_instruction = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    // inputs that would forward and stall if not in reset
    id_rs = {5'd3, 5'd5}; id_src_valid = 2'b11;
    ex_dest = 5'd5; ex_rf_enable = 1'b1; mem_dest = 5'd3; mem_rf_enable = 1'b1;
    ex_load_instruction = 1'b1;
    at_neg();
    chk("rst_fwd_a", 32'(a_fwd), 32'h0);
    chk("rst_pc_a", 32'(a_pc), 32'h1);
    chk("rst_le_a", 32'(a_le), 32'h1);
    chk("rst_nop_a", 32'(a_nop), 32'h0);
    chk("rst_busy_a", 32'(a_busy), 32'h0);
    chk("rst_cnt_a", 32'(a_cnt), 32'h0);
    chk("rst_cnt_b", 32'(b_cnt), 32'h0);
    tick();
    reset_n = 1'b1;
    ex_load_instruction = 1'b0;

    // forwarding EX for op0 (x5), MEM for op1 (x3)
    at_neg();
    chk("fwd_ex_mem_a", 32'(a_fwd), 32'h9);
    chk("fwd_ex_mem_b", 32'(b_fwd), 32'h9);
    chk("fwd_pc", 32'(a_pc), 32'h1);
    chk("fwd_nop", 32'(a_nop), 32'h0);
    tick();

    // priority EX > MEM > WB
    clear_inputs();
    id_rs = {5'd7, 5'd7}; id_src_valid = 2'b11;
    ex_dest = 5'd7; mem_dest = 5'd7; wb_dest = 5'd7;
    ex_rf_enable = 1'b1; mem_rf_enable = 1'b1; wb_rf_enable = 1'b1;
    at_neg(); chk("prio_ex", 32'(a_fwd), 32'h5);
    ex_rf_enable = 1'b0;
    #1; chk("prio_mem", 32'(a_fwd), 32'hA);
    mem_rf_enable = 1'b0;
    #1; chk("prio_wb", 32'(a_fwd), 32'hF);
    id_src_valid = 2'b01;
    #1; chk("valid_mask", 32'(a_fwd), 32'h3);
    wb_rf_enable = 1'b0;
    #1; chk("no_match", 32'(a_fwd), 32'h0);
    tick();

    // x0 never forwards nor stalls
    clear_inputs();
    id_src_valid = 2'b11; ex_dest = 5'd0; ex_rf_enable = 1'b1; ex_load_instruction = 1'b1;
    at_neg();
    chk("x0_fwd", 32'(a_fwd), 32'h0);
    chk("x0_pc", 32'(a_pc), 32'h1);
    chk("x0_nop", 32'(a_nop), 32'h0);
    chk("x0_nop_b", 32'(b_nop), 32'h0);
    tick();
    chk("x0_busy", 32'(a_busy), 32'h0);

    // load-use with 3 bubbles
    clear_inputs();
    drive_load_x7();
    at_neg();
    chk("lu1_nop_a", 32'(a_nop), 32'h1);
    chk("lu1_pc_a", 32'(a_pc), 32'h0);
    chk("lu1_le_a", 32'(a_le), 32'h0);
    chk("lu1_fwd_a", 32'(a_fwd), 32'h1);
    chk("lu1_busy_a", 32'(a_busy), 32'h0);
    chk("lu1_nop_b", 32'(b_nop), 32'h1);
    tick();
    clear_inputs();
    at_neg();
    chk("lu2_nop_a", 32'(a_nop), 32'h1);
    chk("lu2_busy_a", 32'(a_busy), 32'h1);
    chk("lu2_pc_a", 32'(a_pc), 32'h0);
    chk("lu2_cnt_a", 32'(a_cnt), 32'h1);
    chk("lu2_nop_b", 32'(b_nop), 32'h0);
    chk("lu2_busy_b", 32'(b_busy), 32'h0);
    chk("lu2_cnt_b", 32'(b_cnt), 32'h1);
    tick();
    at_neg();
    chk("lu3_nop_a", 32'(a_nop), 32'h1);
    chk("lu3_busy_a", 32'(a_busy), 32'h1);
    chk("lu3_cnt_a", 32'(a_cnt), 32'h2);
    tick();
    at_neg();
    chk("lu4_nop_a", 32'(a_nop), 32'h0);
    chk("lu4_pc_a", 32'(a_pc), 32'h1);
    chk("lu4_busy_a", 32'(a_busy), 32'h0);
    chk("lu4_cnt_a", 32'(a_cnt), 32'h3);
    tick();

    // load-use with ext_stall for 2 cycles during the second bubble
    reset_pulse();
    drive_load_x7();
    at_neg();
    chk("es1_nop_a", 32'(a_nop), 32'h1);
    tick();
    clear_inputs();
    ext_stall = 1'b1;
    at_neg();
    chk("es2_nop_a", 32'(a_nop), 32'h0);
    chk("es2_pc_a", 32'(a_pc), 32'h0);
    chk("es2_le_a", 32'(a_le), 32'h0);
    chk("es2_busy_a", 32'(a_busy), 32'h1);
    chk("es2_pc_b", 32'(b_pc), 32'h0);
    tick();
    at_neg();
    chk("es3_nop_a", 32'(a_nop), 32'h0);
    chk("es3_busy_a", 32'(a_busy), 32'h1);
    chk("es3_cnt_a", 32'(a_cnt), 32'h1);
    tick();
    ext_stall = 1'b0;
    at_neg();
    chk("es4_nop_a", 32'(a_nop), 32'h1);
    chk("es4_busy_a", 32'(a_busy), 32'h1);
    tick();
    at_neg();
    chk("es5_nop_a", 32'(a_nop), 32'h1);
    chk("es5_busy_a", 32'(a_busy), 32'h1);
    tick();
    at_neg();
    chk("es6_nop_a", 32'(a_nop), 32'h0);
    chk("es6_busy_a", 32'(a_busy), 32'h0);
    chk("es6_cnt_a", 32'(a_cnt), 32'h3);
    chk("es6_cnt_b", 32'(b_cnt), 32'h1);
    tick();

    // load-use and flush in the same cycle
    drive_load_x7();
    flush = 1'b1;
    at_neg();
    chk("luf_nop_a", 32'(a_nop), 32'h1);
    chk("luf_pc_a", 32'(a_pc), 32'h1);
    chk("luf_le_a", 32'(a_le), 32'h1);
    chk("luf_nop_b", 32'(b_nop), 32'h1);
    tick();
    clear_inputs();
    at_neg();
    chk("luf_busy_a", 32'(a_busy), 32'h0);
    chk("luf_cnt_a", 32'(a_cnt), 32'h3);
    chk("luf_cnt_b", 32'(b_cnt), 32'h1);
    chk("luf_nop_next", 32'(a_nop), 32'h0);
    tick();

    // flush while in STALL
    drive_load_x7();
    tick();
    clear_inputs();
    flush = 1'b1;
    at_neg();
    chk("fs_busy_a", 32'(a_busy), 32'h1);
    chk("fs_nop_a", 32'(a_nop), 32'h1);
    chk("fs_pc_a", 32'(a_pc), 32'h1);
    chk("fs_cnt_a", 32'(a_cnt), 32'h4);
    tick();
    flush = 1'b0;
    at_neg();
    chk("fs2_busy_a", 32'(a_busy), 32'h0);
    chk("fs2_nop_a", 32'(a_nop), 32'h0);
    chk("fs2_cnt_a", 32'(a_cnt), 32'h4);
    tick();

    // ext_stall suppresses a new load-use entry
    drive_load_x7();
    ext_stall = 1'b1;
    at_neg();
    chk("esl_nop_a", 32'(a_nop), 32'h0);
    chk("esl_pc_a", 32'(a_pc), 32'h0);
    tick();
    clear_inputs();
    at_neg();
    chk("esl_busy_a", 32'(a_busy), 32'h0);
    chk("esl_cnt_a", 32'(a_cnt), 32'h4);
    tick();

    // counter saturation on the 2-bit instance with 5 single-cycle stalls
    reset_pulse();
    drive_load_x7();
    for (int k = 1; k <= 5; k++) begin
      at_neg();
      chk("sat_nop_b", 32'(b_nop), 32'h1);
      tick();
      chk("sat_cnt_b", 32'(b_cnt), (k < 3) ? 32'(k) : 32'h3);
      chk("sat_busy_b", 32'(b_busy), 32'h0);
    end
    chk("sat_cnt_a", 32'(a_cnt), 32'h5);
    chk("sat_busy_a", 32'(a_busy), 32'h1);
    clear_inputs();

    // reset mid-STALL
    reset_n = 1'b0;
    #1;
    chk("rms_busy_a", 32'(a_busy), 32'h0);
    chk("rms_cnt_a", 32'(a_cnt), 32'h0);
    chk("rms_cnt_b", 32'(b_cnt), 32'h0);
    chk("rms_pc_a", 32'(a_pc), 32'h1);
    chk("rms_nop_a", 32'(a_nop), 32'h0);
    reset_n = 1'b1;
    at_neg();
    chk("rms2_nop_a", 32'(a_nop), 32'h0);
    chk("rms2_busy_a", 32'(a_busy), 32'h0);
    tick();
    drive_load_x7();
    at_neg();
    chk("rms3_nop_a", 32'(a_nop), 32'h1);
    tick();
    clear_inputs();
    chk("rms3_busy_a", 32'(a_busy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: number of ID-stage source operands checked (1..3).
REQ-002 Parameter REG_AW, default 5: register-address width.
REQ-003 Parameter LOAD_STALL, default 1: bubble cycles inserted per load-use hazard (1..4).
REQ-004 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 id_rs  input  NUM_SRC*REG_AW  packed ID source addresses; operand i at bits [i*REG_AW +: REG_AW].
REQ-008 id_src_valid  input  NUM_SRC  per-operand "operand is read" flag.
REQ-009 ex_dest, mem_dest, wb_dest  input  REG_AW each  destination addresses of EX/MEM/WB.
REQ-010 ex_rf_enable, mem_rf_enable, wb_rf_enable  input  1 each  stage writes the register file.
REQ-011 ex_load_instruction  input  1  EX holds a load.
REQ-012 flush  input  1  taken branch/jump; squashes ID.
REQ-013 ext_stall  input  1  external hold (memory busy).
REQ-014 fwd_sel  output  2*NUM_SRC  packed per-operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
REQ-015 pc_enable, load_enable  output  1 each  PC / IF-ID register update enables.
REQ-016 nop_signal  output  1  inject bubble into EX.
REQ-017 stall_busy  output  1  FSM in STALL state.
REQ-018 stall_cycles  output  CNT_W  saturating count of bubble cycles.

Function
REQ-019 Operand i SHALL be considered only when id_src_valid[i]=1 and its address is nonzero; register 0 SHALL never forward or stall.
REQ-020 fwd_sel[i] SHALL be combinational, priority EX > MEM > WB, matching when stage rf_enable=1 and dest equals the operand address; otherwise 00; 00 for unconsidered operands.
REQ-021 Load-use hazard (LU) SHALL be: FSM in IDLE, flush=0, ex_load_instruction=1, ex_rf_enable=1, and any considered operand address equals ex_dest.
REQ-022 FSM states SHALL be IDLE and STALL with a down-counter rem of width 2 bits.
REQ-023 IDLE, LU=1, ext_stall=0: same-cycle pc_enable=0, load_enable=0, nop_signal=1; if LOAD_STALL>1 go to STALL with rem=LOAD_STALL-1, else stay IDLE.
REQ-024 STALL, ext_stall=0: pc_enable=0, load_enable=0, nop_signal=1; rem decrements each cycle; transition to IDLE on the cycle rem=1.
REQ-025 LU comparators SHALL be ignored while in STALL (no retrigger or counter reload).
REQ-026 flush=1 SHALL force next state IDLE, rem=0, and nop_signal=1, pc_enable=1, load_enable=1 that cycle; flush SHALL win over simultaneous LU or STALL.
REQ-027 ext_stall=1 without flush SHALL force pc_enable=0, load_enable=0, nop_signal=0, freeze FSM state and rem, and suppress new LU entry.
REQ-028 stall_cycles SHALL increment by 1 on each cycle with nop_signal=1 and flush=0, saturating at 2^CNT_W-1 (no wrap).
REQ-029 With no hazard, flush or ext_stall: pc_enable=1, load_enable=1, nop_signal=0.
REQ-030 stall_busy SHALL equal (state==STALL).

Reset
REQ-031 reset_n=0 SHALL asynchronously force state IDLE, rem=0, stall_cycles=0.
REQ-032 While reset_n=0, outputs SHALL be fwd_sel=0, pc_enable=1, load_enable=1, nop_signal=0, stall_busy=0.
REQ-033 Reset asserted mid-STALL SHALL abandon the stall; first cycle after release SHALL behave as IDLE.

Verification
REQ-034 NUM_SRC=2: id_rs={x3,x5}, valid=11, ex_dest=5, mem_dest=3, both rf_enable=1, no load -> fwd_sel={10,01}, no stall.
REQ-035 id_rs0=0, ex_dest=0, ex_rf_enable=1, ex_load_instruction=1 -> fwd_sel=00, pc_enable=1, nop_signal=0.
REQ-036 LOAD_STALL=3, load to x7 in EX, id_rs0=7 -> nop_signal=1 for exactly 3 cycles, stall_busy high cycles 2-3, stall_cycles=3.
REQ-037 LOAD_STALL=3, ext_stall=1 during second bubble for 2 cycles -> nop_signal=0 those cycles, total bubbles still 3, stall_cycles=3.
REQ-038 LU and flush same cycle -> nop_signal=1, pc_enable=1, state IDLE next, stall_cycles unchanged.
REQ-039 CNT_W=2, 5 consecutive single-cycle stalls -> stall_cycles stops at 3; reset_n pulse mid-STALL -> state IDLE, stall_cycles=0.
